// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed common-anode seven-segment driver
// with frame-synchronous value updates, leading-zero blanking and anti-ghost dead time.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int GHOST_CYC      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    upd_pending
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CW-1:0]           div_cnt;
    logic [IW-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, run;
    logic                    slot_end, frame_end, blanked, dp_nxt;
    logic [3:0]              nib;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    assign slot_end  = div_cnt == CW'(CLK_DIV - 1);
    assign frame_end = slot_end && digit_idx == IW'(NUM_DIGITS - 1);

    // run[k]: digit k and every digit above it are zero with no decimal point
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        if (i == NUM_DIGITS - 1) begin : g_top
            assign run[i] = disp_val[4*i +: 4] == 4'd0 && !disp_dp[i];
        end else begin : g_mid
            assign run[i] = disp_val[4*i +: 4] == 4'd0 && !disp_dp[i] && run[i+1];
        end
    end

    assign nib     = disp_val[4*digit_idx +: 4];
    assign blanked = blank_lz && digit_idx != '0 && run[digit_idx];
    assign seg_nxt = (blanked || (!hex_mode && nib > 4'd9)) ? 7'h00 : FONT[nib];
    assign dp_nxt  = !blanked && disp_dp[digit_idx];
    assign an_nxt  = (enable && int'(div_cnt) >= GHOST_CYC) ? NUM_DIGITS'(1) << digit_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            disp_val    <= '0;
            disp_dp     <= '0;
            upd_pending <= 1'b0;
            seg         <= SEG_OFF;
            dp          <= SEG_ACTIVE_LOW;
            an          <= AN_OFF;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end)
                digit_idx <= frame_end ? '0 : digit_idx + 1'b1;
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
            end
            // display takes the pending value as it stood before any same-edge load
            if (frame_end && upd_pending) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            upd_pending <= load || (upd_pending && !frame_end);
            seg <= seg_nxt ^ SEG_OFF;
            dp  <= dp_nxt ^ SEG_ACTIVE_LOW;
            an  <= an_nxt ^ AN_OFF;
        end
    end
endmodule
